// File: rtl/ctrl_cmd_sequencer_if.sv
// ctrl_cmd_sequencer_if
//   Bundles the host command channel, the controller command channel,
//   the run-status strobes and the sticky error flags of ctrl_cmd_sequencer.
//   master : host/controller side (drives host_*, ctrl_busy, err_clear)
//   slave  : the sequencer itself
interface ctrl_cmd_sequencer_if #(
  parameter int unsigned COMMAND_WIDTH          = 4,
  parameter int unsigned ROW_ADR_WIDTH          = 10,
  parameter int unsigned GOLOBAL_DATA_BUS_WIDTH = 32
);
  // host side
  logic                              host_valid;
  logic                              host_ready;
  logic [COMMAND_WIDTH-1:0]          host_command;
  logic [ROW_ADR_WIDTH-1:0]          host_row_addr;
  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] host_data;
  // controller side
  logic                              ctrl_busy;
  logic                              valid_command;
  logic [COMMAND_WIDTH-1:0]          command;
  logic [ROW_ADR_WIDTH-1:0]          row_addr;
  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] global_data_bus;
  logic                              start;
  // status
  logic                              run_done;
  logic                              seq_idle;
  logic                              instr_overflow;
  logic                              start_timeout;
  logic                              err_clear;

  modport master (
    output host_valid, host_command, host_row_addr, host_data,
    output ctrl_busy, err_clear,
    input  host_ready, valid_command, command, row_addr, global_data_bus,
    input  start, run_done, seq_idle, instr_overflow, start_timeout
  );

  modport slave (
    input  host_valid, host_command, host_row_addr, host_data,
    input  ctrl_busy, err_clear,
    output host_ready, valid_command, command, row_addr, global_data_bus,
    output start, run_done, seq_idle, instr_overflow, start_timeout
  );
endinterface

// File: rtl/ctrl_cmd_sequencer.sv
// ctrl_cmd_sequencer
//   Buffers host commands in a small FIFO and serializes them onto the
//   controller command interface. A START code launches a run and holds
//   off further commands until the controller has gone busy and idle again.
//   Instruction-buffer loads beyond NUM_INSTRUCTION per run are dropped and
//   flagged; a start that is never acknowledged by ctrl_busy is flagged.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     bus        : ctrl_cmd_sequencer_if.slave (host channel, controller
//                  channel, run strobes, sticky flags, err_clear)
module ctrl_cmd_sequencer #(
  parameter int unsigned             COMMAND_WIDTH                        = 4,
  parameter int unsigned             ROW_ADR_WIDTH                        = 10,
  parameter int unsigned             GOLOBAL_DATA_BUS_WIDTH               = 32,
  parameter int unsigned             NUM_INSTRUCTION                      = 4,
  parameter int unsigned             CMD_FIFO_DEPTH                       = 4,
  parameter int unsigned             START_ACK_TIMEOUT                    = 16,
  parameter logic [COMMAND_WIDTH-1:0] COMMAND_CODE_LOAD_INSTRUCTION_BUFFER = 4'b1001,
  parameter logic [COMMAND_WIDTH-1:0] COMMAND_CODE_START                   = 4'b1111
) (
  input  logic                clk,
  input  logic                reset,
  ctrl_cmd_sequencer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LD_W  = $clog2(NUM_INSTRUCTION + 1);
  localparam int unsigned TMO_W = (START_ACK_TIMEOUT > 1) ? $clog2(START_ACK_TIMEOUT) : 1;

  typedef struct packed {
    logic [COMMAND_WIDTH-1:0]          cmd;
    logic [ROW_ADR_WIDTH-1:0]          row;
    logic [GOLOBAL_DATA_BUS_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // FIFO storage and pointers
  entry_t             mem_q [CMD_FIFO_DEPTH];
  entry_t             mem_d [CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // sequencing state
  state_e             state_q, state_d;
  logic [LD_W-1:0]    load_cnt_q, load_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  // registered outputs
  logic                              valid_q, valid_d;
  logic [COMMAND_WIDTH-1:0]          cmd_q, cmd_d;
  logic [ROW_ADR_WIDTH-1:0]          row_q, row_d;
  logic [GOLOBAL_DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic                              start_q, start_d;
  logic                              run_done_q, run_done_d;
  logic                              ovf_q, ovf_d;
  logic                              tmo_flag_q, tmo_flag_d;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  logic   ovf_set;
  logic   tmo_set;
  entry_t head;

  assign full  = (count_q == CNT_W'(CMD_FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Acceptance depends only on the registered occupancy, so a same-cycle
  // pop never reopens a full FIFO.
  assign push  = bus.host_valid & ~full;
  assign head  = mem_q[rd_ptr_q];

  // Command sequencing
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    valid_d    = 1'b0;
    cmd_d      = cmd_q;
    row_d      = row_q;
    data_d     = data_q;
    start_d    = 1'b0;
    run_done_d = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    tmo_set    = 1'b0;

    unique case (state_q)
      ST_ISSUE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.cmd == COMMAND_CODE_START) begin
            start_d    = 1'b1;
            load_cnt_d = '0;
            tmo_cnt_d  = '0;
            state_d    = ST_WAIT_ACK;
          end else if (head.cmd == COMMAND_CODE_LOAD_INSTRUCTION_BUFFER &&
                       load_cnt_q == LD_W'(NUM_INSTRUCTION)) begin
            // instruction buffer already full: drop the load
            ovf_set = 1'b1;
          end else begin
            valid_d = 1'b1;
            cmd_d   = head.cmd;
            row_d   = head.row;
            data_d  = head.data;
            if (head.cmd == COMMAND_CODE_LOAD_INSTRUCTION_BUFFER) begin
              load_cnt_d = load_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_WAIT_ACK: begin
        if (bus.ctrl_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmo_cnt_q == TMO_W'(START_ACK_TIMEOUT - 1)) begin
          tmo_set = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!bus.ctrl_busy) begin
          run_done_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end

      default: state_d = ST_ISSUE;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{cmd: bus.host_command, row: bus.host_row_addr, data: bus.host_data};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Sticky flags: a set in the same cycle as err_clear wins
  always_comb begin
    ovf_d      = ovf_set | (ovf_q      & ~bus.err_clear);
    tmo_flag_d = tmo_set | (tmo_flag_q & ~bus.err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_ISSUE;
      load_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      valid_q    <= 1'b0;
      cmd_q      <= '0;
      row_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      run_done_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      valid_q    <= valid_d;
      cmd_q      <= cmd_d;
      row_q      <= row_d;
      data_q     <= data_d;
      start_q    <= start_d;
      run_done_q <= run_done_d;
      ovf_q      <= ovf_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.host_ready      = ~full;
  assign bus.valid_command   = valid_q;
  assign bus.command         = cmd_q;
  assign bus.row_addr        = row_q;
  assign bus.global_data_bus = data_q;
  assign bus.start           = start_q;
  assign bus.run_done        = run_done_q;
  assign bus.seq_idle        = (state_q == ST_ISSUE) && empty;
  assign bus.instr_overflow  = ovf_q;
  assign bus.start_timeout   = tmo_flag_q;

endmodule

// File: doc/ctrl_cmd_sequencer.md
Name: ctrl_cmd_sequencer

Overview:
Upstream feeder for controller_programmable. Buffers host configuration and launch commands in a small FIFO and serializes them onto the controller command interface (valid_command, command, row_addr, global_data_bus, start). While the controller runs, it withholds further commands until the run completes. It also polices instruction-buffer loads against NUM_INSTRUCTION and flags a missing start acknowledge.

Parameters:
COMMAND_WIDTH, 4, width of the command code
ROW_ADR_WIDTH, 10, row address width
GOLOBAL_DATA_BUS_WIDTH, 32, global data bus width
NUM_INSTRUCTION, 4, controller instruction-buffer depth
CMD_FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
START_ACK_TIMEOUT, 16, cycles to wait for ctrl_busy after start
COMMAND_CODE_LOAD_INSTRUCTION_BUFFER, 4'b1001, instruction-load code
COMMAND_CODE_START, 4'b1111, sequencer-local launch code; never forwarded as a command

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
host_valid  in  1  host command valid
host_ready  out  1  FIFO can accept a command; equals !full
host_command  in  COMMAND_WIDTH  host command code
host_row_addr  in  ROW_ADR_WIDTH  host row address
host_data  in  GOLOBAL_DATA_BUS_WIDTH  host data word
ctrl_busy  in  1  controller not in IDLE
valid_command  out  1  command strobe to the controller
command  out  COMMAND_WIDTH  command to the controller
row_addr  out  ROW_ADR_WIDTH  row address to the controller
global_data_bus  out  GOLOBAL_DATA_BUS_WIDTH  data to the controller
start  out  1  one-cycle launch pulse
run_done  out  1  one-cycle pulse when a run completes
seq_idle  out  1  state is ISSUE and FIFO is empty
instr_overflow  out  1  sticky: too many instruction loads
start_timeout  out  1  sticky: no busy seen after start
err_clear  in  1  clears both sticky flags

Behaviour:
- Only clk is used. Reset is synchronous and active-high.
- Reset values:
  - FIFO empty; state ISSUE.
  - All outputs 0, except host_ready=1 and seq_idle=1.
  - Instruction-load counter = 0; timeout counter = 0.
- FIFO:
  - Push when host_valid & host_ready. Each entry holds {command, row_addr, data}.
  - No bypass: an entry pushed in cycle t is poppable in t+1 at the earliest.
  - Simultaneous push and pop leaves the occupancy unchanged.
  - Pointers wrap modulo CMD_FIFO_DEPTH.
  - host_ready is low whenever occupancy == CMD_FIFO_DEPTH, even if a pop happens in the same cycle.
- All controller-facing outputs are registered. Command latency from host push to valid_command is 2 cycles.
- FSM states: ISSUE, WAIT_ACK, WAIT_DONE.
- ISSUE, FIFO empty: valid_command<=0 next cycle.
- ISSUE, head is a normal command (not START):
  - Pop the head.
  - Next cycle: valid_command=1 and command/row_addr/global_data_bus = entry fields.
  - If the code is LOAD_INSTRUCTION_BUFFER and the load counter == NUM_INSTRUCTION: the entry is dropped (valid_command stays 0) and instr_overflow is set.
  - Otherwise a LOAD increments the load counter.
- ISSUE, head is COMMAND_CODE_START:
  - Pop the head.
  - Next cycle: start=1 for exactly one cycle and valid_command=0.
  - Load counter <= 0; timeout counter <= 0; go to WAIT_ACK.
- WAIT_ACK:
  - No pops.
  - If ctrl_busy: go to WAIT_DONE.
  - Else if timeout counter == START_ACK_TIMEOUT-1: set start_timeout and return to ISSUE.
  - Else increment the timeout counter.
- WAIT_DONE:
  - No pops.
  - When ctrl_busy==0: run_done=1 for one cycle, then return to ISSUE.
- Command/row_addr/global_data_bus hold their last values when valid_command=0.
- Sticky flags are cleared only by reset or err_clear. If err_clear and a set condition occur in the same cycle, the set wins.
- Reset asserted mid-run (WAIT_ACK or WAIT_DONE) discards FIFO contents and returns to ISSUE with no run_done pulse.
- host_ready is independent of FSM state; the FIFO keeps filling during a run.

Test Plan:
- Reset, then push {0000, row 5} and {0011, row 9} back-to-back → valid_command high 2 and 3 cycles after the first push, carrying 0000/5 then 0011/9. seq_idle=1 afterwards.
- Push 5 commands while ctrl_busy holds the FSM in WAIT_DONE → host_ready=0 after the 4th push. After ctrl_busy falls: run_done pulse, then 4 consecutive valid_command cycles.
- Push 5 LOAD_INSTRUCTION_BUFFER commands (NUM_INSTRUCTION=4) → exactly 4 valid_command strobes; instr_overflow=1 after the 5th is popped. err_clear returns it to 0.
- Push START, raise ctrl_busy 3 cycles after the start pulse, drop it 20 cycles later → one start pulse; run_done 1 cycle after ctrl_busy falls; next queued command issued only after that.
- Push START, keep ctrl_busy=0 → start_timeout=1 exactly 16 cycles after entering WAIT_ACK; FSM back in ISSUE and queued commands drain.
- Assert reset during WAIT_DONE with 3 entries queued → next cycle FIFO empty, host_ready=1, all strobes 0, no run_done pulse.
